// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - data SRAM request/response bundle between the pipeline and the responder
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        addr_err;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, stallreq, addr_err
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, stallreq, addr_err
    );
endinterface

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - word RAM slave with byte-lane writes, registered reads and optional wait states
// Optional range checking of the upper address bits is enabled by defining DSRAM_BOUND_CHECK_EN.
module data_sram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    data_sram_responder_if.slave bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              stall;
    logic              do_access;
    logic              out_of_range;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rdata_q;
    logic              addr_err_q;
    logic [31:0]       mem [DEPTH];
    logic              unused_addr_bits;

    assign idx              = bus.data_sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

`ifdef DSRAM_BOUND_CHECK_EN
    assign out_of_range = |bus.data_sram_addr[31:ADDR_W+2];
`else
    assign out_of_range = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        do_access = 1'b0;
        if (WAIT_CYCLES == 0) begin
            do_access = bus.data_sram_en;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stall = bus.data_sram_en;
                    if (bus.data_sram_en) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
                default: begin
                    stall = (cnt_q != 4'd0);
                    // Dropping en while waiting is a pipeline flush: abandon the access.
                    if (!bus.data_sram_en) begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        do_access = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            endcase
        end
        if (!rst) begin
            stall     = 1'b0;
            do_access = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rdata_q    <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_err_q <= do_access & out_of_range;
            if (do_access && bus.data_sram_wen == 4'b0000)
                rdata_q <= out_of_range ? 32'h0 : mem[idx];
        end
    end

    // RAM contents survive reset; only committed, in-range writes touch them.
    always_ff @(posedge clk) begin
        if (do_access && bus.data_sram_wen != 4'b0000 && !out_of_range) begin
            for (int i = 0; i < 4; i++)
                if (bus.data_sram_wen[i])
                    mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign bus.stallreq        = stall;
    assign bus.addr_err        = addr_err_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder with zero and three wait states
module tb_data_sram_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en_s    [2];
    logic [3:0]  wen_s   [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        stall_s [2];
    logic        err_s   [2];

    data_sram_responder_if b0();
    data_sram_responder_if b1();

    assign b0.data_sram_en    = en_s[0];
    assign b0.data_sram_wen   = wen_s[0];
    assign b0.data_sram_addr  = addr_s[0];
    assign b0.data_sram_wdata = wdata_s[0];
    assign rdata_s[0]         = b0.data_sram_rdata;
    assign stall_s[0]         = b0.stallreq;
    assign err_s[0]           = b0.addr_err;
    assign b1.data_sram_en    = en_s[1];
    assign b1.data_sram_wen   = wen_s[1];
    assign b1.data_sram_addr  = addr_s[1];
    assign b1.data_sram_wdata = wdata_s[1];
    assign rdata_s[1]         = b1.data_sram_rdata;
    assign stall_s[1]         = b1.stallreq;
    assign err_s[1]           = b1.addr_err;

    data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct {
        int          due;
        bit          rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    int          waits [2] = '{0, 3};
    exp_t        expq [2][$];
    logic [31:0] mem_m [2][1024];
    logic [31:0] hold_exp [2];
    bit          err_exp [2];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endfunction

    // Monitor: retire due expectations and compare the outputs every cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            err_exp[k] = 1'b0;
            if (!rst) begin
                hold_exp[k] = 32'h0;
                expq[k].delete();
            end else begin
                while (expq[k].size() > 0 && expq[k][0].due == cyc) begin
                    e = expq[k].pop_front();
                    if (e.rd) hold_exp[k] = e.data;
                    err_exp[k] = e.err;
                end
            end
            check("rdata", k, rdata_s[k], hold_exp[k]);
            check("addr_err", k, {31'b0, err_s[k]}, {31'b0, err_exp[k]});
        end
    end

    task automatic access(input int k, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        int          stalls;
        exp_t        e;
        logic [9:0]  idx;
        logic [31:0] mask;
        bit          oob;
        en_s[k] = 1'b1; wen_s[k] = wen; addr_s[k] = addr; wdata_s[k] = wdata;
        stalls = 0;
        @(negedge clk);
        while (stall_s[k] && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        check("stall_cycles", k, stalls, waits[k]);
        idx = addr[11:2];
        oob = 1'b0;
`ifdef DSRAM_BOUND_CHECK_EN
        oob = (addr[31:12] != 20'h0);
`endif
        e.due = cyc + 1; e.rd = (wen == 4'b0000); e.err = oob; e.data = 32'h0;
        if (e.rd) begin
            e.data = oob ? 32'h0 : mem_m[k][idx];
        end else if (!oob) begin
            mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
            mem_m[k][idx] = (mem_m[k][idx] & ~mask) | (wdata & mask);
        end
        expq[k].push_back(e);
        @(posedge clk); #1;
        en_s[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        for (int k = 0; k < 2; k++) begin
            en_s[k] = 1'b1; wen_s[k] = 4'b0000; addr_s[k] = 32'h0; wdata_s[k] = 32'h0;
            hold_exp[k] = 32'h0; err_exp[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("stall_in_reset", 0, {31'b0, stall_s[0]}, 32'h0);
        check("stall_in_reset", 1, {31'b0, stall_s[1]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        en_s[0] = 1'b0; en_s[1] = 1'b0;
        idle(1);

        for (int k = 0; k < 2; k++) begin
            access(k, 4'hF, 32'h0, 32'h12345678);
            access(k, 4'h0, 32'h0, 32'h0);
            access(k, 4'hF, 32'h40, 32'hAABBCCDD);
            access(k, 4'h5, 32'h40, 32'h11223344);
            access(k, 4'h0, 32'h40, 32'h0);
            access(k, 4'h0, 32'h41, 32'h0);
            access(k, 4'hF, 32'h80, 32'hCAFEF00D);
            access(k, 4'h0, 32'h80, 32'h0);
            for (int i = 1; i < 16; i++) access(k, 4'hF, 32'(i) << 2, $urandom);
            idle(1);
        end

        // Flush: drop en in the first WAIT cycle, then a read must see the full wait again.
        access(1, 4'hF, 32'h10, 32'h0);
        en_s[1] = 1'b1; wen_s[1] = 4'hF; addr_s[1] = 32'h10; wdata_s[1] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        en_s[1] = 1'b0;
        @(posedge clk); #1;
        access(1, 4'h0, 32'h10, 32'h0);

        // Reset while a write is waiting.
        en_s[1] = 1'b1; wen_s[1] = 4'hF; addr_s[1] = 32'h10; wdata_s[1] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("stall_in_reset", 1, {31'b0, stall_s[1]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        en_s[1] = 1'b0;
        idle(1);
        access(1, 4'h0, 32'h10, 32'h0);

        for (int k = 0; k < 2; k++) begin
            access(k, 4'hF, 32'h1000, 32'h5A5A5A5A);
            access(k, 4'h0, 32'h0, 32'h0);
            access(k, 4'h0, 32'h1000, 32'h0);
        end

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 60; n++) begin
                w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFF000);
                access(k, w, a, $urandom);
                if ($urandom_range(0, 2) == 0) idle(1);
            end
        end

        idle(3);
        check("queue_drained", 0, expq[0].size(), 32'h0);
        check("queue_drained", 1, expq[1].size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
